// File: rtl/tb_jtag_pkg.sv
// Shared types and helpers for the sysclk-side JTAG bit-vector sequencer.
// Nibble ranges name the half of the vector each side owns at a given time.
package tb_jtag_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int NIB_LO_MSB = 3;
    localparam int NIB_LO_LSB = 0;
    localparam int NIB_HI_MSB = 7;
    localparam int NIB_HI_LSB = 4;

    function automatic logic [2:0] gray2bin3(input logic [2:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

endpackage

// File: rtl/tb_jtag_seq.sv
// Turns the synchronized JTAG bit vectors into valid/ready byte streams,
// touching only the nibble the JTAG side is not currently shifting.
module tb_jtag_seq
    import tb_jtag_pkg::*;
#(
    parameter logic [7:0] FILL_BYTE = 8'hFF,
    parameter int         CNT_W     = 16
) (
    input  logic             sysclk,
    input  logic             sys_rst,
    input  logic             jtag_inactive,
    input  logic [2:0]       jtag_gray,
    input  logic [7:0]       jtag_tdi_vec,
    output logic [7:0]       jtag_tdo_vec,
    output logic [7:0]       tdi_data,
    output logic             tdi_valid,
    input  logic             tdi_ready,
    input  logic [7:0]       tdo_data,
    input  logic             tdo_valid,
    output logic             tdo_ready,
    output logic             active,
    output logic             err_skip,
    output logic             err_overflow,
    output logic             err_underrun,
    input  logic             clr_err,
    output logic [CNT_W-1:0] byte_count
);

    state_e           state_q, state_d;
    logic             entry_q, entry_d;
    logic [2:0]       pos;
    logic [2:0]       pos_q, pos_d;
    logic [2:0]       pos_delta;
    logic [3:0]       lo_nib_q, lo_nib_d;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       tdo_vec_q, tdo_vec_d;
    logic [7:0]       tdi_data_q, tdi_data_d;
    logic             tdi_valid_q, tdi_valid_d;
    logic             err_skip_q, err_skip_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_und_q, err_und_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             run;
    logic             lo_ev;
    logic             hi_ev;
    logic             skip;
    logic [7:0]       tdo_next;

    // Events come from the half bit crossing between the last and current position.
    assign pos       = gray2bin3(jtag_gray);
    assign run       = (state_q == RUN);
    assign lo_ev     = run && !pos_q[2] &&  pos[2];
    assign hi_ev     = run &&  pos_q[2] && !pos[2];
    assign pos_delta = pos - pos_q;
    assign skip      = run && (pos_delta > 3'd1);
    assign tdo_next  = tdo_valid ? tdo_data : FILL_BYTE;

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            entry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!jtag_inactive) state_d = RUN;
            RUN:     if (jtag_inactive)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        entry_d = (state_q == IDLE) && (state_d == RUN);
    end

    always_comb begin
        active    = run;
        tdo_ready = run && tdo_valid && (entry_q || lo_ev);
    end

    always_comb begin
        pos_d       = pos;
        lo_nib_d    = lo_nib_q;
        hold_d      = hold_q;
        tdo_vec_d   = tdo_vec_q;
        tdi_data_d  = tdi_data_q;
        tdi_valid_d = tdi_valid_q && !tdi_ready;
        count_d     = count_q;
        // Clear first so a coincident error event below still sets the flag.
        err_skip_d  = err_skip_q && !clr_err;
        err_ovf_d   = err_ovf_q  && !clr_err;
        err_und_d   = err_und_q  && !clr_err;

        if (!run) begin
            pos_d     = 3'd0;
            lo_nib_d  = 4'd0;
            hold_d    = FILL_BYTE;
            tdo_vec_d = tdo_next;
        end else begin
            if (entry_q) begin
                hold_d    = tdo_next;
                tdo_vec_d = tdo_next;
            end
            if (skip) begin
                err_skip_d = 1'b1;
            end
            if (lo_ev) begin
                lo_nib_d = jtag_tdi_vec[NIB_LO_MSB:NIB_LO_LSB];
                hold_d   = tdo_next;
                tdo_vec_d[NIB_LO_MSB:NIB_LO_LSB] = tdo_next[NIB_LO_MSB:NIB_LO_LSB];
                if (!tdo_valid) begin
                    err_und_d = 1'b1;
                end
            end
            if (hi_ev) begin
                count_d = count_q + CNT_W'(1);
                tdo_vec_d[NIB_HI_MSB:NIB_HI_LSB] = hold_q[NIB_HI_MSB:NIB_HI_LSB];
                if (!tdi_valid_q || tdi_ready) begin
                    tdi_data_d  = {jtag_tdi_vec[NIB_HI_MSB:NIB_HI_LSB], lo_nib_q};
                    tdi_valid_d = 1'b1;
                end else begin
                    err_ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            pos_q       <= 3'd0;
            lo_nib_q    <= 4'd0;
            hold_q      <= FILL_BYTE;
            tdo_vec_q   <= FILL_BYTE;
            tdi_data_q  <= 8'd0;
            tdi_valid_q <= 1'b0;
            err_skip_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_und_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            pos_q       <= pos_d;
            lo_nib_q    <= lo_nib_d;
            hold_q      <= hold_d;
            tdo_vec_q   <= tdo_vec_d;
            tdi_data_q  <= tdi_data_d;
            tdi_valid_q <= tdi_valid_d;
            err_skip_q  <= err_skip_d;
            err_ovf_q   <= err_ovf_d;
            err_und_q   <= err_und_d;
            count_q     <= count_d;
        end
    end

    assign jtag_tdo_vec = tdo_vec_q;
    assign tdi_data     = tdi_data_q;
    assign tdi_valid    = tdi_valid_q;
    assign err_skip     = err_skip_q;
    assign err_overflow = err_ovf_q;
    assign err_underrun = err_und_q;
    assign byte_count   = count_q;

endmodule

// File: doc/tb_jtag_seq.md
# tb_jtag_seq

Sysclk-domain sequencer for the JTAG clock-crossing block: it watches the synchronized 3-bit gray bit-position counter and turns the 8-bit TDI/TDO bit vectors into byte streams. In the TDI direction it produces a valid/ready byte stream. In the TDO direction it consumes a valid/ready byte stream. Reads and writes use nibble ping-pong, so the sysclk side only touches the half of each vector the JTAG side is not using. It sits between the clock-crossing block and the protocol/command layer.

## Interface
- FILL_BYTE, 8'hFF: TDO value driven when no byte is available or while idle.
- CNT_W, 16: width of byte_count.
- sysclk  in  1  system clock; the only clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- jtag_inactive  in  1  synchronized "JTAG in reset / register not selected".
- jtag_gray  in  3  synchronized gray code of the last-written bit index.
- jtag_tdi_vec  in  8  synchronized TDI bit vector.
- jtag_tdo_vec  out  8  TDO bit vector presented to the crossing block.
- tdi_data  out  8  received byte; bit 0 is the first bit shifted.
- tdi_valid  out  1  tdi_data valid.
- tdi_ready  in  1  consumer accepts tdi_data.
- tdo_data  in  8  byte to shift out.
- tdo_valid  in  1  tdo_data valid.
- tdo_ready  out  1  single-cycle pop of tdo_data.
- active  out  1  state is RUN.
- err_skip, err_overflow, err_underrun  out  1 each  sticky error flags.
- clr_err  in  1  clears all sticky flags; when it coincides with a new error event, the set wins.
- byte_count  out  CNT_W  number of TDI bytes formed, wrapping.

## Operation
- pos = gray-to-binary(jtag_gray), registered as pos_q. half = pos[2]. Transition events are evaluated only in RUN.
  - LO event: half changes 0→1. Bits 0-3 are stable.
  - HI event: half changes 1→0. Bits 4-7 are stable.
- States:
  - IDLE: jtag_inactive=1. jtag_tdo_vec = tdo_data if tdo_valid, else FILL_BYTE; nothing is popped. pos_q is forced to 0. Go to RUN when jtag_inactive=0.
  - RUN, on entry cycle: pop the byte shown in IDLE if tdo_valid (tdo_ready=1), and hold it as byte 0. Go to IDLE when jtag_inactive=1.
- TDI path:
  - LO event: latch jtag_tdi_vec[3:0] into lo_nib.
  - HI event: form {jtag_tdi_vec[7:4], lo_nib}.
  - If the output register is empty, or is being accepted in the same cycle, load it and set tdi_valid. Otherwise drop the byte and set err_overflow.
  - byte_count increments for every formed byte, including dropped ones.
- TDO path:
  - LO event: if tdo_valid, pop it (tdo_ready=1 for that cycle) into hold. Otherwise load FILL_BYTE into hold and set err_underrun. Write hold[3:0] into jtag_tdo_vec[3:0].
  - HI event: write hold[7:4] into jtag_tdo_vec[7:4].
- Skip check: each cycle in RUN, (pos − pos_q) mod 8 must be 0 or 1. Any other value sets err_skip. pos_q still takes the new value, and the half events implied by the jump are processed normally.
- Leaving RUN mid-byte:
  - lo_nib and hold are discarded.
  - A byte already in the tdi_data register stays valid until accepted.
- sys_rst mid-operation clears everything immediately, including a pending tdi_data.

## Timing
- Reset values:
  - jtag_tdo_vec=FILL_BYTE, tdi_data=0, tdi_valid=0, tdo_ready=0, active=0.
  - All err_* = 0, byte_count=0, state=IDLE.
- Event detection:
  - An event is detected in the cycle in which the new jtag_gray is sampled.
  - tdi_valid and the jtag_tdo_vec nibble update are registered and visible one cycle later.
  - tdo_ready is combinational within the event cycle.
- tdi handshake: a transfer happens when tdi_valid && tdi_ready at a rising edge. Data stays stable while valid && !ready.
- tdo handshake: a pop happens only in a cycle with tdo_ready=1 and tdo_valid=1.
- Clock requirement: sysclk ≥ 4× TCK. At that ratio each nibble write lands at least 2 TCK before the JTAG side reads that nibble. err_skip flags a violation.
- active rises 1 cycle after jtag_inactive falls. It falls 1 cycle after jtag_inactive rises.

## Structure
- Package tb_jtag_pkg holds:
  - state enum {IDLE, RUN};
  - function gray2bin3;
  - localparam NIB_LO/NIB_HI index ranges.
- Single module with no sub-module. Gray decode and event detection are a few lines using the package function.

## Test plan
- Reset held, then released with jtag_inactive=1 and tdo_valid=0 → jtag_tdo_vec=8'hFF, tdi_valid=0, all errors 0.
- jtag_gray stepped 0..7,0 one step per 4 sysclk, with jtag_tdi_vec=8'hA5 stable → after the HI event, tdi_data=8'hA5, tdi_valid=1, byte_count=1.
- Before activation, tdo_valid=1 with tdo_data=8'h3C, then a second byte 8'hC3 offered → jtag_tdo_vec=8'h3C in IDLE, popped on RUN entry. At the LO event, 8'hC3 is popped and jtag_tdo_vec[3:0]=4'h3. At the HI event, jtag_tdo_vec[7:4]=4'hC.
- tdi_ready=0 across two full byte periods → first byte held, second dropped, err_overflow=1, byte_count=2. clr_err with no new event → err_overflow=0.
- tdo_valid=0 at a LO event → hold=8'hFF, err_underrun=1, tdo_ready stays 0.
- jtag_gray jumps from gray(1) to gray(5) → err_skip=1 and a LO event is processed. Then jtag_inactive=1 at pos=6 → state=IDLE, active=0, and the partial byte is never emitted.
